life_result_tx: RTL and testbench
=================================

LIFE_RESULT_TX -- requirements
Module: life_result_tx

Interface
REQ-001 SHALL have parameter INIT, default 20, meaning the soup edge length; record width W = INIT*INIT+64.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of result records buffered; it is a power of two and at least 2.
REQ-003 SHALL have derived localparam NBYTES = ceil(W/8), which is 58 at default.
REQ-004 clk  input  1  is the single clock; all logic is on the rising edge.
REQ-005 reset  input  1  is the synchronous, active-low reset.
REQ-006 life  input  1  is a one-cycle strobe from the core marking a qualifying soup.
REQ-007 life_data  input  W  holds {boundact[31:0], step_count[31:0], rng_init[INIT*INIT-1:0]} and is valid when life=1.
REQ-008 tx_data  output  8  is the stream byte.
REQ-009 tx_valid  output  1  means tx_data is valid.
REQ-010 tx_ready  input  1  means the sink accepts the byte; a transfer occurs when tx_valid and tx_ready are both 1.
REQ-011 tx_last  output  1  marks the final byte of a frame.
REQ-012 fifo_count  output  $clog2(DEPTH)+1  gives the number of records held.
REQ-013 drop_count  output  16  counts records lost while the FIFO was full; it saturates at 16'hFFFF.
REQ-014 busy  output  1  is 1 whenever the FSM is not in IDLE or fifo_count is nonzero.

Function
REQ-015 SHALL capture life_data into the FIFO on every clk edge where life=1, unless the FIFO is full.
REQ-016 SHALL accept a capture into a full FIFO when a pop occurs on the same edge; otherwise the record is dropped and drop_count increments.
REQ-017 SHALL implement the FSM states IDLE, HEADER and PAYLOAD.
REQ-018 IDLE -> HEADER when the FIFO is non-empty: pop the oldest record into a W-bit shift register, assert tx_valid, and drive tx_data=8'hA5.
REQ-019 HEADER -> PAYLOAD on a transfer; the byte counter is set to 0 and tx_data becomes record bits [7:0].
REQ-020 PAYLOAD SHALL send byte k = record bits [8k+7:8k] for k = 0..NBYTES-1, LSB first, with bits at or above W zero-padded.
REQ-021 tx_last SHALL be 1 only while k = NBYTES-1.
REQ-022 On a transfer with k = NBYTES-1: go to IDLE and deassert tx_valid on the next cycle; there is no back-to-back frame without one IDLE cycle.
REQ-023 While tx_valid=1 and tx_ready=0, tx_data, tx_last and the state SHALL hold stable.
REQ-024 tx_valid SHALL never drop without a transfer, except on reset.
REQ-025 Frame length SHALL be 1+NBYTES bytes, which is 59 at default.
REQ-026 Latency: a life strobe at edge N with the FIFO empty and the FSM in IDLE gives the record written at N, the pop at N+1, and tx_valid=1 after edge N+1.
REQ-027 The FIFO read and write pointers SHALL wrap modulo DEPTH; fifo_count tracks pushes minus pops exactly.
REQ-028 Captures SHALL continue during frame transmission; the record in the shift register is no longer counted in fifo_count.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 When reset=0 at a clk edge: state=IDLE, tx_valid=0, tx_last=0, tx_data=0, fifo_count=0, drop_count=0, busy=0, and the pointers are cleared.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no further bytes; buffered records are discarded.
REQ-032 life is ignored during reset.

Verification
REQ-033 Single record: life=1 with boundact=7, step_count=759, rng_init=400'h1 and tx_ready=1 -> 59 bytes A5, 01, 00 x49, F7, 02, 00, 00, 07, 00, 00, 00; tx_last only on byte 59; tx_valid high 2 cycles after the strobe.
REQ-034 Backpressure: toggle tx_ready at random with about 30% duty -> identical byte sequence, no byte duplicated or skipped, and tx_data stable while stalled.
REQ-035 Overflow: tx_ready=0 and 6 strobes with DEPTH=4 -> 1 record in the shift register, fifo_count=4, drop_count=1; after tx_ready=1, 5 complete frames emerge in strobe order.
REQ-036 Simultaneous push and pop: FIFO full, FSM in IDLE, life strobed on the pop edge -> record accepted, fifo_count stays 4, drop_count unchanged.
REQ-037 Reset mid-frame: reset=0 after byte 20 of a frame with 2 records queued -> next cycle tx_valid=0, fifo_count=0, busy=0; a new strobe then yields a fresh, complete frame.
REQ-038 Saturation: force more than 65535 drops -> drop_count holds at 16'hFFFF.

Source files
------------

// File: rtl/life_result_tx.sv
// life_result_tx: buffers qualifying soup records from the Life core in a small
// FIFO and streams each one as a byte frame: header 8'hA5, then the record LSB
// byte first, zero-padded to a whole number of bytes.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous active-low reset
//   life       - one-cycle strobe, life_data is valid
//   life_data  - {boundact[31:0], step_count[31:0], rng_init[INIT*INIT-1:0]}
//   tx_data    - stream byte
//   tx_valid   - tx_data valid
//   tx_ready   - sink accepts byte (transfer when tx_valid & tx_ready)
//   tx_last    - final byte of a frame
//   fifo_count - records held in the FIFO (excludes the one being sent)
//   drop_count - records lost to a full FIFO, saturating
//   busy       - FSM not idle or FIFO non-empty
module life_result_tx #(
  parameter int unsigned INIT  = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      life,
  input  logic [INIT*INIT+63:0]     life_data,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_last,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               drop_count,
  output logic                      busy
);

  localparam int unsigned W      = INIT * INIT + 64;
  localparam int unsigned NBYTES = (W + 7) / 8;
  localparam int unsigned PW     = NBYTES * 8;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned KW     = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [PW-1:0] sh_q,       sh_d;
  logic [KW-1:0] k_q,        k_d;
  logic [AW-1:0] wr_q,       wr_d;
  logic [AW-1:0] rd_q,       rd_d;
  logic [CW-1:0] count_q,    count_d;
  logic [15:0]   drop_q,     drop_d;
  logic [7:0]    tx_data_q,  tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q,  tx_last_d;
  logic          busy_q,     busy_d;

  logic [W-1:0]  mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic          drop;
  logic          xfer;

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    k_d        = k_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    drop_d     = drop_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    xfer       = tx_valid_q & tx_ready;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          sh_d       = PW'(mem_q[rd_q]);
          tx_valid_d = 1'b1;
          tx_data_d  = 8'hA5;
          tx_last_d  = 1'b0;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          state_d   = S_PAYLOAD;
          k_d       = '0;
          tx_data_d = sh_q[7:0];
          sh_d      = sh_q >> 8;
          tx_last_d = 1'b0;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          if (k_q == KW'(NBYTES - 1)) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            tx_data_d  = 8'h00;
          end else begin
            k_d       = k_q + KW'(1);
            tx_data_d = sh_q[7:0];
            sh_d      = sh_q >> 8;
            // the byte now being loaded is the last one when k reaches NBYTES-1
            tx_last_d = (k_q == KW'(NBYTES - 2));
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase

    // a full FIFO still accepts when the same edge pops
    push = life & ((count_q != CW'(DEPTH)) | pop);
    drop = life & ~push;

    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    busy_d = (state_d != S_IDLE) | (count_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      k_q        <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      k_q        <= k_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
    end
  end

  // Record storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_q] <= life_data;
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;
  assign fifo_count = count_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_life_result_tx.sv
// tb_life_result_tx: randomized and directed stimulus for life_result_tx,
// checked against a transaction-level model (record queue + frame byte index).
module tb_life_result_tx;

  localparam int unsigned INIT   = 20;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned W      = INIT * INIT + 64;
  localparam int unsigned NBYTES = (W + 7) / 8;
  localparam int unsigned PW     = NBYTES * 8;
  localparam int unsigned RW     = ((W + 31) / 32) * 32;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          life;
  logic [W-1:0]  life_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_last;
  logic [CW-1:0] fifo_count;
  logic [15:0]   drop_count;
  logic          busy;

  life_result_tx #(.INIT(INIT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .life       (life),
    .life_data  (life_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [W-1:0]  q_rec[$];
  int            cnt        = 0;
  int            drops      = 0;
  bit            in_frame   = 1'b0;
  int            byte_idx   = 0;
  int            frames_done = 0;
  logic [PW-1:0] cur_rec    = '0;
  logic [7:0]    fb [0:NBYTES];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] rand_rec();
    logic [RW-1:0] t;
    for (int i = 0; i < int'(RW / 32); i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [7:0] exp_byte(input int idx);
    if (idx == 0) return 8'hA5;
    return cur_rec[8*(idx-1) +: 8];
  endfunction

  // One clock: drive at negedge, observe #1 after posedge, advance the model
  task automatic step(input bit lf, input logic [W-1:0] ld, input bit rdy, input bit rst_n);
    logic v, xf, exp_pop, obs_pop, idle_before;
    logic [7:0] d;
    int cnt_before;
    @(negedge clk);
    life = lf; life_data = ld; tx_ready = rdy; reset = rst_n;
    v = tx_valid; d = tx_data;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q_rec.delete(); cnt = 0; drops = 0; in_frame = 1'b0; byte_idx = 0;
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_last",  64'(tx_last),  64'd0);
      check("rst_data",  64'(tx_data),  64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_drop",  64'(drop_count), 64'd0);
      check("rst_busy",  64'(busy),     64'd0);
      return;
    end
    idle_before = !in_frame;
    cnt_before  = cnt;
    xf = v && rdy;
    if (xf && in_frame) begin
      fb[byte_idx] = d;
      byte_idx++;
      if (byte_idx > int'(NBYTES)) begin
        in_frame = 1'b0;
        frames_done++;
      end
    end
    exp_pop = idle_before && (cnt_before > 0);
    obs_pop = tx_valid && !v;
    check("pop_timing", 64'(obs_pop), 64'(exp_pop));
    if (exp_pop) begin
      cur_rec  = PW'(q_rec.pop_front());
      in_frame = 1'b1;
      byte_idx = 0;
      cnt--;
    end
    if (lf) begin
      if (cnt_before < int'(DEPTH) || exp_pop) begin
        q_rec.push_back(ld);
        cnt++;
      end else begin
        drops++;
      end
    end
    check("tx_valid", 64'(tx_valid), 64'(in_frame));
    check("tx_last",  64'(tx_last),  64'(in_frame && byte_idx == int'(NBYTES)));
    if (in_frame) check("tx_data", 64'(tx_data), 64'(exp_byte(byte_idx)));
    check("fifo_count", 64'(fifo_count), 64'(cnt));
    check("drop_count", 64'(drop_count), (drops > 65535) ? 64'hFFFF : 64'(drops));
    check("busy", 64'(busy), 64'(in_frame || cnt != 0));
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((in_frame || cnt != 0) && n < max_cyc) begin
      step(1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    check("drain_timeout", 64'(in_frame || cnt != 0), 64'd0);
  endtask

  initial begin
    logic [W-1:0] r;
    int fd, n;
    life = 1'b0; life_data = '0; tx_ready = 1'b0; reset = 1'b0;

    // reset, with life strobed to show it is ignored
    for (int i = 0; i < 3; i++) step(1'b1, rand_rec(), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // single known record, ready held high
    r = '0;
    r[0] = 1'b1;
    r[INIT*INIT +: 32]      = 32'd759;
    r[INIT*INIT + 32 +: 32] = 32'd7;
    step(1'b1, r, 1'b1, 1'b1);
    check("lat_n_valid", 64'(tx_valid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("lat_n1_valid", 64'(tx_valid), 64'd1);
    check("lat_n1_hdr", 64'(tx_data), 64'hA5);
    fd = frames_done;
    drain(200);
    check("single_frames", 64'(frames_done - fd), 64'd1);
    check("b0_hdr",  64'(fb[0]),  64'hA5);
    check("b1_rng",  64'(fb[1]),  64'h01);
    check("b2_zero", 64'(fb[2]),  64'h00);
    check("b51_sc",  64'(fb[51]), 64'hF7);
    check("b52_sc",  64'(fb[52]), 64'h02);
    check("b55_ba",  64'(fb[55]), 64'h07);
    check("b58_ba",  64'(fb[58]), 64'h00);

    // overflow: six strobes while stalled
    for (int i = 0; i < 6; i++) step(1'b1, rand_rec(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_count", 64'(fifo_count), 64'd4);
    check("ovf_drop",  64'(drop_count), 64'd1);
    fd = frames_done;
    drain(1000);
    check("ovf_frames", 64'(frames_done - fd), 64'd5);

    // simultaneous push and pop on a full FIFO with the FSM idle
    for (int i = 0; i < 5; i++) step(1'b1, rand_rec(), 1'b0, 1'b1);
    check("pp_full", 64'(fifo_count), 64'd4);
    n = 0;
    while (!(tx_valid && tx_last) && n < 200) begin
      step(1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    check("pp_reach_last", 64'(tx_valid && tx_last), 64'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, rand_rec(), 1'b1, 1'b1);
    check("pp_count", 64'(fifo_count), 64'd4);
    check("pp_drop",  64'(drop_count), 64'd1);
    drain(2000);

    // reset in mid-frame with two records queued
    for (int i = 0; i < 3; i++) step(1'b1, rand_rec(), 1'b0, 1'b1);
    n = 0;
    while (byte_idx < 20 && n < 200) begin
      step(1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    check("mid_count", 64'(fifo_count), 64'd2);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("post_rst_valid", 64'(tx_valid), 64'd0);
    fd = frames_done;
    step(1'b1, rand_rec(), 1'b1, 1'b1);
    drain(200);
    check("post_rst_frames", 64'(frames_done - fd), 64'd1);

    // random strobes with ~30% ready
    for (int i = 0; i < 8000; i++)
      step($urandom_range(99) < 2, rand_rec(), $urandom_range(99) < 30, 1'b1);
    drain(3000);

    // drop counter saturation
    r = rand_rec();
    for (int i = 0; i < 65545; i++) step(1'b1, r, 1'b0, 1'b1);
    check("sat_drop", 64'(drop_count), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
